alu_serial_seq: RTL and testbench

// Bit-serial N-bit ALU sequencer. Latches two N-bit operands on a start

---
 rtl/alu_serial_seq_pkg.sv | 17 +
 rtl/alu_1b.sv | 40 ++++
 rtl/alu_serial_seq.sv | 139 +++++++++++++
 tb/tb_alu_serial_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_serial_seq_pkg.sv
// Shared encodings for the bit-serial ALU sequencer and its 1-bit cell.
//   alu_op_t : ALU opcode (XOR / OR / AND / ADD)
//   ST_*     : sequencer FSM state encodings
package alu_serial_seq_pkg;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t ALU_XOR = 2'b00;
  localparam alu_op_t ALU_OR  = 2'b01;
  localparam alu_op_t ALU_AND = 2'b10;
  localparam alu_op_t ALU_ADD = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_1b.sv
// 1-bit ALU cell.
//   A, B   : operand bits
//   invA/B : invert the operand bit before the op
//   Cin    : carry in (ADD only)
//   Op     : ALU_XOR / ALU_OR / ALU_AND / ALU_ADD
//   Out    : result bit
//   Cout   : carry out; 0 for the logic ops so no carry leaks between bits
module alu_1b
  import alu_serial_seq_pkg::*;
(
  input  logic    A,
  input  logic    B,
  input  logic    Cin,
  input  alu_op_t Op,
  input  logic    invA,
  input  logic    invB,
  output logic    Out,
  output logic    Cout
);

  logic a, b;

  assign a = A ^ invA;
  assign b = B ^ invB;

  always_comb begin
    Out  = 1'b0;
    Cout = 1'b0;
    case (Op)
      ALU_XOR: Out = a ^ b;
      ALU_OR:  Out = a | b;
      ALU_AND: Out = a & b;
      default: begin
        Out  = a ^ b ^ Cin;
        Cout = (a & b) | (a & Cin) | (b & Cin);
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial N-bit ALU sequencer.  Operands are latched on an accepted start
// and fed LSB-first through a single alu_1b cell, one bit per clock, with the
// carry held in a flop between bits.
//   clk, rst             : clock, synchronous active-high reset
//   start                : request, accepted in IDLE or DONE only
//   A, B, Op, invA, invB, Cin : operation, sampled on the accepting edge
//   busy                 : high while bits are processed (RUN)
//   done                 : one-cycle pulse, results valid
//   Out, Cout, Ofl, Zero : result and flags, held until the next final bit
module alu_serial_seq
  import alu_serial_seq_pkg::*;
#(
  parameter int N  = 16,
  parameter int CW = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  alu_op_t      Op,
  input  logic         invA,
  input  logic         invB,
  input  logic         Cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Out,
  output logic         Cout,
  output logic         Ofl,
  output logic         Zero
);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  opa_q, opa_d;
  logic [N-1:0]  opb_q, opb_d;
  logic [N-1:0]  res_q, res_d;
  logic [N-1:0]  out_q, out_d;
  alu_op_t       op_q, op_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          ofl_q, ofl_d;
  logic          zero_q, zero_d;

  logic          cell_out, cell_cout;

  // Inversion is folded in when the operands are latched, so the cell never
  // inverts on its own.
  alu_1b u_cell (
    .A    (opa_q[0]),
    .B    (opb_q[0]),
    .Cin  (carry_q),
    .Op   (op_q),
    .Out  (cell_out),
    .invA (1'b0),
    .invB (1'b0),
    .Cout (cell_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    out_d   = out_q;
    op_d    = op_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ofl_d   = ofl_q;
    zero_d  = zero_q;
    case (state_q)
      ST_RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        // Result fills from the MSB end; after N shifts bit 0 is the LSB.
        res_d   = {cell_out, res_q[N-1:1]};
        carry_d = cell_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          state_d = ST_DONE;
          out_d   = res_d;
          zero_d  = (res_d == '0);
          cout_d  = (op_q == ALU_ADD) & cell_cout;
          // carry_q here is the carry into the MSB.
          ofl_d   = (op_q == ALU_ADD) & (carry_q ^ cell_cout);
        end
      end
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_RUN;
          opa_d   = A ^ {N{invA}};
          opb_d   = B ^ {N{invB}};
          op_d    = Op;
          carry_d = Cin & (Op == ALU_ADD);
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      out_q   <= '0;
      op_q    <= ALU_XOR;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ofl_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      out_q   <= out_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ofl_q   <= ofl_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign Out  = out_q;
  assign Cout = cout_q;
  assign Ofl  = ofl_q;
  assign Zero = zero_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
module tb_alu_serial_seq;
  import alu_serial_seq_pkg::*;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst, start, invA, invB, Cin;
  logic [N-1:0] A, B;
  alu_op_t      Op;
  logic         busy, done, Cout, Ofl, Zero;
  logic [N-1:0] Out;

  int npass = 0;
  int ntot  = 0;

  logic [N-1:0] exp_out, prev_out;
  logic         exp_cout, exp_ofl, exp_zero;

  alu_serial_seq #(.N(N), .CW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Op(Op),
    .invA(invA), .invB(invB), .Cin(Cin), .busy(busy), .done(done),
    .Out(Out), .Cout(Cout), .Ofl(Ofl), .Zero(Zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference: whole-word arithmetic on the (optionally inverted) operands.
  task automatic model(input logic [N-1:0] a_in, input logic [N-1:0] b_in, input alu_op_t op,
                       input logic ia, input logic ib, input logic ci);
    logic [N-1:0] a, b;
    logic [N:0]   sum;
    a = ia ? ~a_in : a_in;
    b = ib ? ~b_in : b_in;
    exp_cout = 1'b0;
    exp_ofl  = 1'b0;
    case (op)
      ALU_XOR: exp_out = a ^ b;
      ALU_OR:  exp_out = a | b;
      ALU_AND: exp_out = a & b;
      default: begin
        sum      = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
        exp_out  = sum[N-1:0];
        exp_cout = sum[N];
        exp_ofl  = (a[N-1] == b[N-1]) && (exp_out[N-1] != a[N-1]);
      end
    endcase
    exp_zero = (exp_out == '0);
  endtask

  // Drive one request through its accepting edge, then scramble the inputs
  // to show they are only sampled on that edge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input alu_op_t op,
                       input logic ia, input logic ib, input logic ci);
    model(a, b, op, ia, ib, ci);
    A = a; B = b; Op = op; invA = ia; invB = ib; Cin = ci;
    start = 1'b1;
    tick();
    start = 1'b0;
    A = N'($urandom); B = N'($urandom); Op = alu_op_t'($urandom_range(0, 3));
    invA = 1'($urandom); invB = 1'($urandom); Cin = 1'($urandom);
  endtask

  // Called in cycle 1 of an op; returns in the DONE cycle.
  task automatic finish_op(input string tag, input bit noise);
    int cyc = 1;
    while (done !== 1'b1 && cyc < N + 4) begin
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".hold"}, 32'(Out), 32'(prev_out));
      if (noise) begin
        start = 1'b1;
        A = N'($urandom); B = N'($urandom);
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, 32'(cyc), 32'(N + 1));
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy_done"}, 32'(busy), 32'd0);
    chk({tag, ".Out"}, 32'(Out), 32'(exp_out));
    chk({tag, ".Cout"}, 32'(Cout), 32'(exp_cout));
    chk({tag, ".Ofl"}, 32'(Ofl), 32'(exp_ofl));
    chk({tag, ".Zero"}, 32'(Zero), 32'(exp_zero));
    prev_out = exp_out;
  endtask

  task automatic idle_chk(input string tag);
    tick();
    chk({tag, ".idle_done"}, 32'(done), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ".idle_Out"}, 32'(Out), 32'(prev_out));
    chk({tag, ".idle_Zero"}, 32'(Zero), 32'(exp_zero));
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Op = ALU_XOR;
    invA = 1'b0; invB = 1'b0; Cin = 1'b0;
    tick(); tick();
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.Out", 32'(Out), 32'd0);
    chk("rst.Cout", 32'(Cout), 32'd0);
    chk("rst.Ofl", 32'(Ofl), 32'd0);
    chk("rst.Zero", 32'(Zero), 32'd0);
    rst = 1'b0;
    prev_out = '0;
    tick();

    // Directed arithmetic and boundary cases
    issue(16'h0003, 16'h0005, ALU_ADD, 0, 0, 0); finish_op("add3_5", 0);     idle_chk("add3_5");
    issue(16'h7FFF, 16'h0001, ALU_ADD, 0, 0, 0); finish_op("add_ofl", 0);    idle_chk("add_ofl");
    issue(16'hFFFF, 16'h0001, ALU_ADD, 0, 0, 0); finish_op("add_wrap", 0);   idle_chk("add_wrap");
    issue(16'h0005, 16'h0005, ALU_ADD, 0, 1, 1); finish_op("sub5_5", 0);     idle_chk("sub5_5");
    issue(16'h8000, 16'h8000, ALU_ADD, 0, 0, 0); finish_op("add_negofl", 0); idle_chk("add_negofl");
    // Logic ops; Cin set to show carry is ignored
    issue(16'hF0F0, 16'hFF00, ALU_XOR, 0, 0, 1); finish_op("xor", 0);        idle_chk("xor");
    issue(16'hF0F0, 16'hFF00, ALU_OR,  0, 0, 1); finish_op("or", 0);         idle_chk("or");
    issue(16'hF0F0, 16'hFF00, ALU_AND, 0, 0, 1); finish_op("and", 0);        idle_chk("and");
    issue(16'hF0F0, 16'hFF00, ALU_AND, 1, 0, 0); finish_op("and_invA", 0);   idle_chk("and_invA");

    // start asserted on every RUN cycle with changing operands: ignored
    issue(16'h1234, 16'h4321, ALU_ADD, 0, 0, 1); finish_op("noise", 1);      idle_chk("noise");

    // start held in DONE: next op starts with no IDLE cycle
    issue(16'hAAAA, 16'h5555, ALU_ADD, 0, 0, 1); finish_op("b2b_a", 0);
    issue(16'h00FF, 16'h0F0F, ALU_XOR, 0, 1, 0); finish_op("b2b_b", 0);      idle_chk("b2b_b");

    // Randomized ops, randomly back-to-back or with an idle gap
    for (int i = 0; i < 24; i++) begin
      issue(N'($urandom), N'($urandom), alu_op_t'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom));
      finish_op($sformatf("rnd%0d", i), bit'($urandom));
      if ($urandom_range(0, 1) == 0) idle_chk($sformatf("rnd%0d", i));
    end
    idle_chk("rnd_end");

    // Reset in cycle 8 of an ADD aborts it with no done
    issue(16'h1111, 16'h2222, ALU_ADD, 0, 0, 0);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.Out", 32'(Out), 32'd0);
    chk("abort.Zero", 32'(Zero), 32'd0);
    prev_out = '0;
    ndone = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("abort.no_done", 32'(ndone), 32'd0);
    issue(16'h0102, 16'h0304, ALU_ADD, 0, 0, 1); finish_op("post_abort", 0); idle_chk("post_abort");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
